// File: rtl/pwm_duty_ramp_ctrl.sv
// rtl/pwm_duty_ramp_ctrl.sv - steps PWM duty toward a commanded target on period boundaries
module pwm_duty_ramp_ctrl #(
    parameter int DW = 8,
    parameter int HW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [DW-1:0] cfg_target,
    input  logic [DW-1:0] cfg_step,
    input  logic [HW-1:0] cfg_hold,
    input  logic          cfg_abort,
    input  logic          period_end,
    output logic [DW-1:0] duty_out,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, RAMP, DONE} state_t;

    localparam logic [DW-1:0] STEP_ONE = DW'(1);
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);

    state_t        state, state_nxt;
    logic [DW-1:0] target_r, step_r;
    logic [HW-1:0] hold_r, hold_cnt;
    logic          accept, up, hold_more, period_hit, step_due;
    logic [HW:0]   hold_inc;
    logic [DW:0]   diff;
    logic [DW-1:0] duty_calc, duty_step;

    assign cfg_ready = ena && (state == IDLE);
    assign busy      = (state == RAMP);
    assign done      = (state == DONE);
    assign accept    = cfg_valid && cfg_ready;

    // Distance to target is taken in DW+1 bits so the saturation test never wraps;
    // the raw add/subtract is only used when it stays strictly short of the target.
    always_comb begin
        hold_inc   = {1'b0, hold_cnt} + {{HW{1'b0}}, 1'b1};
        hold_more  = hold_inc < {1'b0, hold_r};
        up         = target_r > duty_out;
        diff       = up ? ({1'b0, target_r} - {1'b0, duty_out})
                        : ({1'b0, duty_out} - {1'b0, target_r});
        duty_calc  = up ? (duty_out + step_r) : (duty_out - step_r);
        duty_step  = (diff <= {1'b0, step_r}) ? target_r : duty_calc;
        period_hit = ena && (state == RAMP) && !cfg_abort && period_end;
        step_due   = period_hit && !hold_more;
    end

    always_comb begin
        state_nxt = state;
        if (ena) begin
            case (state)
                IDLE: if (accept) state_nxt = (cfg_target == duty_out) ? DONE : RAMP;
                RAMP: begin
                    if (cfg_abort)
                        state_nxt = IDLE;
                    else if (step_due && (duty_step == target_r))
                        state_nxt = DONE;
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            duty_out <= '0;
            hold_cnt <= '0;
            target_r <= '0;
            step_r   <= '0;
            hold_r   <= '0;
        end else if (ena) begin
            state <= state_nxt;
            if (accept) begin
                target_r <= cfg_target;
                step_r   <= (cfg_step == '0) ? STEP_ONE : cfg_step;
                hold_r   <= (cfg_hold == '0) ? HOLD_ONE : cfg_hold;
                hold_cnt <= '0;
            end else if (period_hit) begin
                if (hold_more) begin
                    hold_cnt <= hold_inc[HW-1:0];
                end else begin
                    hold_cnt <= '0;
                    duty_out <= duty_step;
                end
            end
        end
    end

endmodule

// File: doc/pwm_duty_ramp_ctrl.md
Name: pwm_duty_ramp_ctrl

Overview:
Controller that sequences the duty-cycle input of the PWM generator core inside tt_um_pwm_top. It accepts a ramp command (target duty, step size, periods per step) over a valid/ready handshake. It then walks the duty register toward the target, one step per programmed number of PWM periods. Duty changes occur only on PWM period boundaries (period_end pulse from the core), so the output waveform never glitches mid-period.

Parameters:
DW, 8, width of duty, target and step values
HW, 8, width of the hold (periods-per-step) count

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous, active-low
ena  input  1  design enable; low freezes all state
cfg_valid  input  1  command present
cfg_ready  output  1  controller can accept command
cfg_target  input  DW  target duty
cfg_step  input  DW  duty increment per step; 0 treated as 1
cfg_hold  input  HW  PWM periods per step; 0 treated as 1
cfg_abort  input  1  stop ramp, keep current duty
period_end  input  1  one-cycle pulse from PWM core at counter wrap
duty_out  output  DW  registered duty to PWM core
busy  output  1  high in RAMP
done  output  1  one-cycle pulse when target reached

Behaviour:
- Reset (rst_n low, async): state IDLE, duty_out=0, hold_cnt=0, done=0, busy=0. Latched target/step/hold are cleared to 0.
- cfg_ready = ena && (state==IDLE), combinational. A command is accepted on a clock edge with cfg_valid && cfg_ready.
- States: IDLE, RAMP, DONE.
- IDLE:
  - On accept, latch target, step' = max(cfg_step,1) and hold' = max(cfg_hold,1), and clear hold_cnt.
  - If cfg_target == duty_out, go to DONE. Otherwise go to RAMP.
- RAMP:
  - busy=1.
  - On each cycle with period_end=1: if hold_cnt+1 < hold', then hold_cnt++. Otherwise, set hold_cnt=0 and update duty_out on that same edge.
  - Update rule, computed in DW+1 bits: moving up, duty_out = (target-duty_out <= step') ? target : duty_out+step'. Moving down, mirror this using duty_out-target. No overshoot and no wrap, including step'=2^DW-1.
  - If the new duty_out == target, go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then go to IDLE.
- cfg_abort:
  - In RAMP it has priority over period_end: go to IDLE next edge, duty_out unchanged, no done pulse.
  - Ignored in IDLE and DONE.
- ena=0: state, hold_cnt and duty_out hold; period_end and cfg_abort are ignored; cfg_ready=0. A done pulse already in DONE also stalls until ena returns.
- Latency:
  - duty_out changes on the edge that samples the qualifying period_end.
  - The PWM core is required to latch duty at its next period start, so one full period is applied per step value.
- A period_end coinciding with the accept edge is not counted.
- cfg_valid while busy is not accepted. The requester holds it until ready.
- No reset mid-operation recovery is needed beyond the async reset: outputs go to their reset values immediately on rst_n falling.

Test Plan:
- Reset: assert rst_n=0 mid-RAMP with duty_out=0x40 -> duty_out=0, busy=0, done=0 immediately; cfg_ready=1 after release with ena=1.
- Up-ramp: duty 0, command target=0x10, step=4, hold=2, pulse period_end every 16 cycles -> duty 4,8,12,16 on every 2nd pulse; done one cycle after reaching 0x10; busy drops.
- Down-ramp with saturation: duty 0x10, command target=0x03, step=5, hold=1 -> duty 0x0B, 0x06, 0x03 (no underflow), then done.
- Zero fields and large step: target=0xFF, step=0, hold=0 from 0xFE -> one period_end gives 0xFF. From 0x01, step=0xFF gives 0xFF without wrap.
- Equal target: command target equal to current duty -> done next cycle, no period_end needed, duty unchanged.
- Abort and ena: cfg_abort with period_end in the same cycle mid-RAMP -> IDLE, duty unchanged, no done. ena=0 for 3 period_end pulses -> no duty change, cfg_ready=0.
